// File: rtl/muldiv_sequencer_pkg.sv
// Shared core types for the HI/LO multiply/divide resource: op and state enums,
// and the FUNCT-field decode the control unit uses to select an operation.
package global_types;

   typedef logic [31:0] logic32;
   typedef logic [5:0]  funct_t;

   localparam funct_t FUNCT_MULT  = 6'h18;
   localparam funct_t FUNCT_MULTU = 6'h19;
   localparam funct_t FUNCT_DIV   = 6'h1A;
   localparam funct_t FUNCT_DIVU  = 6'h1B;

   typedef enum logic [1:0] {
      MULT  = 2'd0,
      MULTU = 2'd1,
      DIV   = 2'd2,
      DIVU  = 2'd3
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      FIXUP = 2'd2
   } muldiv_state_t;

   function automatic logic is_muldiv_funct(input funct_t funct);
      return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
             (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
   endfunction

   function automatic muldiv_op_t funct_to_muldiv_op(input funct_t funct);
      muldiv_op_t op;
      case (funct)
         FUNCT_MULTU: op = MULTU;
         FUNCT_DIV:   op = DIV;
         FUNCT_DIVU:  op = DIVU;
         default:     op = MULT;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequencer datapath: a shift-add multiply step (LSB first)
// or a restoring-division step (MSB first), selected by is_div.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic             is_div,
   input  logic [WIDTH:0]   acc_hi,
   input  logic [WIDTH-1:0] acc_lo,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH:0]   next_hi,
   output logic [WIDTH-1:0] next_lo
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   always_comb begin
      // Multiply: acc_hi is the upper product half (top bit stays 0), acc_lo the multiplier.
      sum     = acc_hi + (acc_lo[0] ? {1'b0, operand} : '0);
      // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
      shifted = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
      diff    = shifted - {1'b0, operand};
      if (is_div) begin
         next_hi = diff[WIDTH] ? shifted : diff;
         next_lo = {acc_lo[WIDTH-2:0], ~diff[WIDTH]};
      end else begin
         next_hi = {1'b0, sum[WIDTH:1]};
         next_lo = {sum[0], acc_lo[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers; one bit per
// cycle, with a stall to the pipeline when HI/LO is touched during an operation.
module muldiv_sequencer
   import global_types::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  muldiv_op_t       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             hilo_access,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] hilo_wd,
   output logic             busy,
   output logic             done,
   output logic             stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output muldiv_state_t    dbg_state
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   muldiv_state_t      state;
   logic [CW-1:0]      count;
   logic [WIDTH:0]     acc_hi;
   logic [WIDTH-1:0]   acc_lo;
   logic [WIDTH-1:0]   operand;
   logic               is_div;
   logic               neg_hi;
   logic               neg_lo;
   logic [WIDTH:0]     next_hi;
   logic [WIDTH-1:0]   next_lo;
   logic               op_div;
   logic               op_signed;
   logic               sign_xor;
   logic [WIDTH-1:0]   rs_abs;
   logic [WIDTH-1:0]   rt_abs;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_neg;
   logic [WIDTH-1:0]   hi_res;
   logic [WIDTH-1:0]   lo_res;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div  (is_div),
      .acc_hi  (acc_hi),
      .acc_lo  (acc_lo),
      .operand (operand),
      .next_hi (next_hi),
      .next_lo (next_lo)
   );

   always_comb begin
      op_div    = (op == DIV) || (op == DIVU);
      op_signed = (op == MULT) || (op == DIV);
      sign_xor  = op_signed & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
      rs_abs    = (op_signed && rs_data[WIDTH-1]) ? -rs_data : rs_data;
      rt_abs    = (op_signed && rt_data[WIDTH-1]) ? -rt_data : rt_data;
      prod      = {acc_hi[WIDTH-1:0], acc_lo};
      prod_neg  = -prod;
      if (is_div) begin
         hi_res = neg_hi ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
         lo_res = neg_lo ? -acc_lo : acc_lo;
      end else begin
         {hi_res, lo_res} = neg_lo ? prod_neg : prod;
      end
   end

   assign stall     = hilo_access & busy;
   assign dbg_state = state;

   // Handshake: start is taken only in IDLE with busy low; busy stays high through the
   // done cycle and drops on the following edge, so the next start lands the cycle after done.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         count   <= '0;
         acc_hi  <= '0;
         acc_lo  <= '0;
         operand <= '0;
         is_div  <= 1'b0;
         neg_hi  <= 1'b0;
         neg_lo  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (!busy && hi_we) hi <= hilo_wd;
               if (!busy && lo_we) lo <= hilo_wd;
               if (start && !busy) begin
                  busy   <= 1'b1;
                  is_div <= op_div;
                  count  <= CW'(WIDTH - 1);
                  if (op_div && (rt_data == '0)) begin
                     // Divide by zero bypasses CALC; FIXUP passes these through unsigned.
                     acc_hi  <= {1'b0, rs_data};
                     acc_lo  <= '1;
                     operand <= '0;
                     neg_hi  <= 1'b0;
                     neg_lo  <= 1'b0;
                     state   <= FIXUP;
                  end else begin
                     acc_hi  <= '0;
                     acc_lo  <= op_div ? rs_abs : rt_abs;
                     operand <= op_div ? rt_abs : rs_abs;
                     neg_lo  <= sign_xor;
                     neg_hi  <= op_div ? (op_signed & rs_data[WIDTH-1]) : sign_xor;
                     state   <= CALC;
                  end
               end else begin
                  busy <= 1'b0;
               end
            end
            CALC: begin
               acc_hi <= next_hi;
               acc_lo <= next_lo;
               if (count == '0) begin
                  state <= FIXUP;
               end else begin
                  count <= count - CW'(1);
               end
            end
            FIXUP: begin
               hi    <= hi_res;
               lo    <= lo_res;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
